// File: rtl/imm_encoder.sv
// imm_encoder: inverse of the datapath immediate extender.
// Turns a 32-bit constant or signed byte offset into the 24-bit
// Instr[23:0] immediate field that the extender decodes back to that value.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   request valid
//   in_ready   block can accept a request (IDLE and not in reset)
//   in_value   constant (DP) or signed byte offset (mem, branch)
//   in_src     00 DP rotated imm, 01 memory offset, 10 branch, 11 unsupported
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   out_field  encoded immediate field, 0 when not encodable
//   out_ok     value is encodable
//   out_up     memory U bit (1 = add), 0 for other sources
//
// state  | meaning
// IDLE   | waiting for a request; rotation 0 is tested at the accept edge
// SEARCH | testing one DP rotation per cycle, starting at rotation 1
// DONE   | result held until out_valid && out_ready
module imm_encoder #(
    parameter int ROT_STEPS = 16,
    parameter int MEM_MAX   = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic [1:0]  in_src,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_field,
    output logic        out_ok,
    output logic        out_up
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam logic [3:0]         ROT_LAST = 4'(ROT_STEPS - 1);
    localparam logic signed [31:0] MEM_HI   = 32'(MEM_MAX);
    localparam logic signed [31:0] MEM_LO   = -MEM_HI;

    state_t      state;
    logic [31:0] value;
    logic [3:0]  rot;

    logic [5:0]         rol_sh;
    logic [31:0]        rol_val;
    logic signed [31:0] in_sv;
    logic               mem_ok;
    logic [11:0]        mem_mag;
    logic               br_ok;

    // ROL by 2r; a right shift by 32 yields 0, so r = 0 needs no special case.
    assign rol_sh  = {1'b0, rot, 1'b0};
    assign rol_val = (value << rol_sh) | (value >> (6'd32 - rol_sh));

    // Range check is done on the signed value first, so the magnitude only
    // needs its low 12 bits and 0x80000000 can never overflow into a result.
    assign in_sv   = $signed(in_value);
    assign mem_ok  = (in_sv >= MEM_LO) && (in_sv <= MEM_HI);
    assign mem_mag = in_value[31] ? (~in_value[11:0] + 12'd1) : in_value[11:0];

    // Word aligned and sign-extended from bit 25.
    assign br_ok = (in_value[1:0] == 2'b00) &&
                   ((in_value[31:25] == 7'h00) || (in_value[31:25] == 7'h7f));

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            value     <= 32'd0;
            rot       <= 4'd0;
            out_field <= 24'd0;
            out_ok    <= 1'b0;
            out_up    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        value     <= in_value;
                        rot       <= 4'd0;
                        out_field <= 24'd0;
                        out_ok    <= 1'b0;
                        out_up    <= 1'b0;
                        state     <= DONE;
                        case (in_src)
                            2'b00: begin
                                // Rotation 0 is checked here so a plain 8-bit
                                // constant completes as fast as a memory offset.
                                if (in_value[31:8] == 24'd0) begin
                                    out_field <= {16'd0, in_value[7:0]};
                                    out_ok    <= 1'b1;
                                end else if (ROT_STEPS > 1) begin
                                    rot   <= 4'd1;
                                    state <= SEARCH;
                                end
                            end
                            2'b01: begin
                                if (mem_ok) begin
                                    out_field <= {12'd0, mem_mag};
                                    out_ok    <= 1'b1;
                                    out_up    <= ~in_value[31];
                                end
                            end
                            2'b10: begin
                                if (br_ok) begin
                                    out_field <= in_value[25:2];
                                    out_ok    <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                SEARCH: begin
                    if (rol_val[31:8] == 24'd0) begin
                        out_field <= {12'd0, rot, rol_val[7:0]};
                        out_ok    <= 1'b1;
                        state     <= DONE;
                    end else if (rot == ROT_LAST) begin
                        state <= DONE;
                    end else begin
                        rot <= rot + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

    localparam int ROT_STEPS = 16;
    localparam int MEM_MAX   = 4095;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_value = 32'd0;
    logic [1:0]  in_src = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_field;
    logic        out_ok;
    logic        out_up;

    imm_encoder #(.ROT_STEPS(ROT_STEPS), .MEM_MAX(MEM_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_src    (in_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_field (out_field),
        .out_ok    (out_ok),
        .out_up    (out_up)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] field;
        logic        ok;
        logic        up;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   compared = 0;
    int   mismatched = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
    bit   mon_busy = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        compared++;
        mismatched++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] v, input int s);
        if (s == 0) return v;
        return (v >> s) | (v << (32 - s));
    endfunction

    // Reference: brute-force the forward extender over every (rotation, byte)
    // pair for DP; plain signed arithmetic for memory and branch offsets.
    function automatic exp_t model(input logic [31:0] v, input logic [1:0] src);
        exp_t   e;
        longint sv;
        e.field = 24'd0;
        e.ok    = 1'b0;
        e.up    = 1'b0;
        e.lat   = 1;
        e.acc   = 0;
        sv      = longint'($signed(v));
        case (src)
            2'b00: begin
                e.lat = ROT_STEPS;
                for (int r = 0; r < ROT_STEPS && !e.ok; r++) begin
                    for (int b = 0; b < 256; b++) begin
                        if (ror32(32'(b), 2 * r) == v) begin
                            e.ok    = 1'b1;
                            e.field = {12'd0, 4'(r), 8'(b)};
                            e.lat   = r + 1;
                            break;
                        end
                    end
                end
            end
            2'b01: begin
                if (sv >= -longint'(MEM_MAX) && sv <= longint'(MEM_MAX)) begin
                    e.ok    = 1'b1;
                    e.up    = (sv >= 0);
                    e.field = 24'((sv < 0) ? -sv : sv);
                end
            end
            2'b10: begin
                if ((sv % 4 == 0) && (sv >= -(64'sd1 <<< 25)) && (sv <= (64'sd1 <<< 25) - 4)) begin
                    e.ok    = 1'b1;
                    e.field = 24'(sv / 4);
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic send(input logic [31:0] v, input logic [1:0] s);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("in_ready_timeout");
            return;
        end
        e     = model(v, s);
        e.acc = cyc + 1;
        sbq.push_back(e);
        in_value = v;
        in_src   = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each new result, checks hold stability.
    initial begin
        exp_t        e;
        logic [23:0] hf;
        logic        hok, hup;
        hf = 24'd0; hok = 1'b0; hup = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_busy = 0;
            end else if (out_valid) begin
                chk("in_ready_in_done", 32'(in_ready), 32'd0);
                if (!mon_busy) begin
                    mon_busy = 1;
                    if (sbq.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        e = sbq.pop_front();
                        chk("field", 32'(out_field), 32'(e.field));
                        chk("ok", 32'(out_ok), 32'(e.ok));
                        chk("up", 32'(out_up), 32'(e.up));
                        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    end
                    hf = out_field; hok = out_ok; hup = out_up;
                end else begin
                    chk("hold_field", 32'(out_field), 32'(hf));
                    chk("hold_ok", 32'(out_ok), 32'(hok));
                    chk("hold_up", 32'(out_up), 32'(hup));
                end
                if (out_ready) mon_busy = 0;
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || mon_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || mon_busy) fail_now("drain_timeout");
    endtask

    logic [31:0] dir_val [21] = '{
        32'h000000FF, 32'h00000000, 32'hFF000000, 32'hF000000F, 32'h00000101,
        32'hFFFFFFFC, 32'h00000FFF, 32'h00001000, 32'h80000000, 32'hFFFFF001,
        32'hFFFFF000, 32'h00000000,
        32'hFFFFFFF8, 32'h01FFFFFC, 32'h00000006, 32'h02000000, 32'hFE000000,
        32'hFDFFFFFC, 32'h12345678, 32'h000000FF, 32'hC0000003
    };
    logic [1:0] dir_src [21] = '{
        2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
        2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
        2'd1, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd2, 2'd3, 2'd3, 2'd0
    };

    initial begin
        logic [31:0] v;
        logic [1:0]  s;
        int          n;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_field", 32'(out_field), 32'd0);
        chk("rst_ok", 32'(out_ok), 32'd0);
        chk("rst_up", 32'(out_up), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // directed corner cases
        for (int i = 0; i < 21; i++) send(dir_val[i], dir_src[i]);
        drain();

        // unencodable DP holds in_ready low for the whole search
        send(32'h00000101, 2'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            chk("search_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("search_timeout");
        drain();

        // backpressure: 3 cycles with out_ready low and stray in_valid
        rdy_mode = 2;
        send(32'h00000FFF, 2'd1);
        @(negedge clk);
        if (!out_valid) fail_now("bp_no_valid");
        repeat (3) begin
            in_valid = 1'b1;
            in_value = $urandom;
            in_src   = 2'd1;
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();

        // reset in the middle of a search (rotation 2)
        @(negedge clk);
        in_value = 32'hFF000000;
        in_src   = 2'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        send(32'h000000FF, 2'd0);
        drain();

        // randomized traffic with random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 160; i++) begin
            s = 2'($urandom_range(0, 3));
            case (s)
                2'd0: begin
                    case ($urandom_range(0, 2))
                        0:       v = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
                        1:       v = $urandom;
                        default: v = 32'($urandom_range(0, 1023)) << $urandom_range(0, 22);
                    endcase
                end
                2'd1: begin
                    if ($urandom_range(0, 3) == 0) v = $urandom;
                    else v = 32'($signed($urandom_range(0, 9000)) - 4500);
                end
                2'd2: begin
                    v = $urandom;
                    if ($urandom_range(0, 2) != 0) v = {{7{v[25]}}, v[24:2], 2'b00};
                end
                default: v = $urandom;
            endcase
            send(v, s);
        end
        rdy_mode = 0;
        drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
